uart_cmd_sequencer: RTL and testbench

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

---
 rtl/uart_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Command sequencer driven by UART bytes. From IDLE it decodes command bytes:
// vector writes (0x01 / 0x02) steer the BRAM write controller and own the
// address counter, and operation commands (0x10-0x17) launch the processing
// unit once both vectors hold valid data.
// Optional feature macro: CMD_TIMEOUT_EN adds an idle watchdog to the write
// states. If the watchdog times out, the write is abandoned and timeout_err
// pulses. Without the macro, timeout_err is tied low and a write state can
// wait indefinitely.
module uart_cmd_sequencer #(
    parameter int N              = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       wr_addr_inc,
    input  logic       wr_job_ok,
    input  logic       proc_done,
    output logic [9:0] addr,
    output logic       wr_en_ctrl,
    output logic       sel_a,
    output logic       sel_b,
    output logic       proc_start,
    output logic [2:0] proc_op,
    output logic       busy,
    output logic       cmd_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE_A  = 3'd1,
        ST_WRITE_B  = 3'd2,
        ST_START_OP = 3'd3,
        ST_WAIT_OP  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_WRITE_A = 8'h01;
    localparam logic [7:0] CMD_WRITE_B = 8'h02;
    localparam logic [4:0] CMD_OP_HI   = 5'b00010;   // 0x10-0x17 share this upper field
    localparam logic [9:0] ADDR_LAST   = 10'(N - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [9:0] addr_r;
    logic [2:0] proc_op_r;
    logic       vec_a_valid_r;
    logic       vec_b_valid_r;
    logic       cmd_err_r;
    logic       cmd_err_s;
    logic       is_op_cmd_s;
    logic       in_write_s;
    logic       timeout_hit_s;

    assign is_op_cmd_s = (rx_data[7:3] == CMD_OP_HI);
    assign in_write_s  = (state_r == ST_WRITE_A) || (state_r == ST_WRITE_B);

`ifdef CMD_TIMEOUT_EN
    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_err_r;

    // Any write-path activity in the same cycle keeps the write alive.
    assign timeout_hit_s = in_write_s && !rx_ready && !wr_addr_inc
                           && (tmo_cnt_r == TMO_LAST);

    // Idle watchdog: counts quiet cycles in the write states only.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r     <= {TW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            // A completed job on the expiry cycle wins; no error is reported.
            timeout_err_r <= timeout_hit_s && !wr_job_ok;
            if (!in_write_s || rx_ready || wr_addr_inc || timeout_hit_s) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and command-error detection.
    always_comb begin
        next_state_s = state_r;
        cmd_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_ready) begin
                    if (rx_data == CMD_WRITE_A) begin
                        next_state_s = ST_WRITE_A;
                    end else if (rx_data == CMD_WRITE_B) begin
                        next_state_s = ST_WRITE_B;
                    end else if (is_op_cmd_s && vec_a_valid_r && vec_b_valid_r) begin
                        next_state_s = ST_START_OP;
                    end else begin
                        // Unknown byte, or an operation before both vectors are valid.
                        next_state_s = ST_IDLE;
                        cmd_err_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITE_A, ST_WRITE_B: begin
                if (wr_job_ok || timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_START_OP: begin
                next_state_s = ST_WAIT_OP;
            end
            ST_WAIT_OP: begin
                // Bytes arriving while an operation runs are dropped and flagged.
                cmd_err_s = rx_ready;
                if (proc_done) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_OP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        wr_en_ctrl = 1'b0;
        sel_a      = 1'b0;
        sel_b      = 1'b0;
        proc_start = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_WRITE_A: begin
                wr_en_ctrl = 1'b1;
                sel_a      = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE_B: begin
                wr_en_ctrl = 1'b1;
                sel_b      = 1'b1;
                busy       = 1'b1;
            end
            ST_START_OP: begin
                proc_start = 1'b1;
                busy       = 1'b1;
            end
            ST_WAIT_OP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Address counter, operation code and vector-valid bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r        <= 10'd0;
            proc_op_r     <= 3'd0;
            vec_a_valid_r <= 1'b0;
            vec_b_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_WRITE_A) begin
                        addr_r        <= 10'd0;
                        vec_a_valid_r <= 1'b0;
                    end else if (next_state_s == ST_WRITE_B) begin
                        addr_r        <= 10'd0;
                        vec_b_valid_r <= 1'b0;
                    end else if (next_state_s == ST_START_OP) begin
                        proc_op_r <= rx_data[2:0];
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                ST_WRITE_A, ST_WRITE_B: begin
                    if (wr_job_ok) begin
                        // Job completion overrides a coincident address advance.
                        addr_r <= 10'd0;
                        if (state_r == ST_WRITE_A) begin
                            vec_a_valid_r <= 1'b1;
                        end else begin
                            vec_b_valid_r <= 1'b1;
                        end
                    end else if (timeout_hit_s) begin
                        // Abandoned write: the vector stays invalid.
                        addr_r <= 10'd0;
                    end else if (wr_addr_inc) begin
                        if (addr_r == ADDR_LAST) begin
                            addr_r <= 10'd0;
                        end else begin
                            addr_r <= addr_r + 10'd1;
                        end
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // Registered one-cycle command-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err_r <= 1'b0;
        end else begin
            cmd_err_r <= cmd_err_s;
        end
    end

    assign addr    = addr_r;
    assign proc_op = proc_op_r;
    assign cmd_err = cmd_err_r;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer. Event outputs (cmd_err, proc_start with
// proc_op, timeout_err) are matched against a queue of expected events.
module tb_uart_cmd_sequencer;

    localparam int N_WORDS = 1024;
    localparam int TMO     = 16;

    localparam logic [7:0] EV_CMD_ERR = 8'h80;
    localparam logic [7:0] EV_TIMEOUT = 8'h40;
    localparam logic [7:0] EV_START   = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_addr_inc = 1'b0;
    logic       wr_job_ok = 1'b0;
    logic       proc_done = 1'b0;
    logic [9:0] addr;
    logic       wr_en_ctrl;
    logic       sel_a;
    logic       sel_b;
    logic       proc_start;
    logic [2:0] proc_op;
    logic       busy;
    logic       cmd_err;
    logic       timeout_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] obs_ev;
    logic [7:0] exp_ev;
    logic [9:0] exp_addr;

    uart_cmd_sequencer #(
        .N              (N_WORDS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .wr_addr_inc (wr_addr_inc),
        .wr_job_ok   (wr_job_ok),
        .proc_done   (proc_done),
        .addr        (addr),
        .wr_en_ctrl  (wr_en_ctrl),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .proc_start  (proc_start),
        .proc_op     (proc_op),
        .busy        (busy),
        .cmd_err     (cmd_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Every event pulse seen on the falling edge must match the next expected one.
    always @(negedge clk) begin
        if (cmd_err === 1'b1 || proc_start === 1'b1 || timeout_err === 1'b1) begin
            obs_ev = 8'h00;
            if (cmd_err)     obs_ev = obs_ev | EV_CMD_ERR;
            if (timeout_err) obs_ev = obs_ev | EV_TIMEOUT;
            if (proc_start)  obs_ev = obs_ev | EV_START | {5'd0, proc_op};
            if (sb_q.size() > 0) exp_ev = sb_q.pop_front();
            else                 exp_ev = 8'h00;
            check_eq("event", {24'd0, obs_ev}, {24'd0, exp_ev});
        end
    end

    initial begin
        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_addr", {22'd0, addr}, 32'd0);
        check_eq("rst_flags", {25'd0, wr_en_ctrl, sel_a, sel_b, proc_start, busy, cmd_err, timeout_err}, 32'd0);
        check_eq("rst_op", {29'd0, proc_op}, 32'd0);
        rst = 1'b0;
        step();

        // Operation with no valid vectors, then an unknown byte.
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h12);
        @(negedge clk);
        check_eq("op_novec_idle", {31'd0, busy}, 32'd0);
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h55);
        @(negedge clk);
        check_eq("bad_byte_idle", {31'd0, busy}, 32'd0);

        // Vector A: N words, job_ok on the last one.
        send_byte(8'h01);
        @(negedge clk);
        check_eq("a_entry_addr", {22'd0, addr}, 32'd0);
        check_eq("a_entry_dec", {28'd0, wr_en_ctrl, sel_a, sel_b, busy}, 32'b1101);
        for (int i = 0; i < N_WORDS; i++) begin
            wr_addr_inc = 1'b1;
            wr_job_ok   = (i == N_WORDS - 1);
            step();
            wr_addr_inc = 1'b0;
            wr_job_ok   = 1'b0;
            exp_addr = (i == N_WORDS - 1) ? 10'd0 : 10'(i + 1);
            @(negedge clk);
            check_eq("a_addr", {22'd0, addr}, {22'd0, exp_addr});
            if (i < N_WORDS - 1)
                check_eq("a_dec", {28'd0, wr_en_ctrl, sel_a, sel_b, busy}, 32'b1101);
            if (i == 10) begin
                // Bytes during a write are data, not commands.
                send_byte(8'h13);
                @(negedge clk);
                check_eq("a_passthru", {21'd0, busy, addr}, {21'd1, 10'd11});
            end
        end
        check_eq("a_done_busy", {31'd0, busy}, 32'd0);

        // Only A valid: operation refused.
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h12);
        @(negedge clk);
        check_eq("op_a_only_idle", {31'd0, busy}, 32'd0);

        // Vector B: wrap at N-1, one more word, then job_ok alone.
        send_byte(8'h02);
        for (int i = 0; i < N_WORDS + 1; i++) begin
            wr_addr_inc = 1'b1;
            step();
            wr_addr_inc = 1'b0;
            exp_addr = 10'((i + 1) % N_WORDS);
            @(negedge clk);
            check_eq("b_addr", {22'd0, addr}, {22'd0, exp_addr});
        end
        check_eq("b_dec", {28'd0, wr_en_ctrl, sel_a, sel_b, busy}, 32'b1011);
        wr_job_ok = 1'b1;
        step();
        wr_job_ok = 1'b0;
        @(negedge clk);
        check_eq("b_done", {21'd0, busy, addr}, 32'd0);

        // Write/processing pulses are ignored in IDLE.
        wr_addr_inc = 1'b1; wr_job_ok = 1'b1; proc_done = 1'b1;
        step();
        wr_addr_inc = 1'b0; wr_job_ok = 1'b0; proc_done = 1'b0;
        @(negedge clk);
        check_eq("idle_ignore", {21'd0, busy, addr}, 32'd0);

        // Operation 3 with a byte dropped during WAIT_OP.
        sb_q.push_back(EV_START | 8'h03);
        send_byte(8'h13);
        @(negedge clk);
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        step();
        @(negedge clk);
        check_eq("wait_state", {28'd0, busy, proc_start, proc_op}, {28'd0, 1'b1, 1'b0, 3'd3});
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h01);
        @(negedge clk);
        check_eq("wait_drop", {28'd0, busy, sel_a, wr_en_ctrl, 1'b0}, 32'b1000);
        repeat (4) step();
        @(negedge clk);
        check_eq("wait_hold", {28'd0, busy, proc_op}, {28'd0, 1'b1, 3'd3});
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        @(negedge clk);
        check_eq("op3_done", {31'd0, busy}, 32'd0);

        // Operation 7.
        sb_q.push_back(EV_START | 8'h07);
        send_byte(8'h17);
        step();
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        @(negedge clk);
        check_eq("op7_done", {28'd0, busy, proc_op}, {28'd0, 1'b0, 3'd7});

        // Reset at addr 500 during WRITE_B.
        send_byte(8'h02);
        for (int i = 0; i < 500; i++) begin
            wr_addr_inc = 1'b1;
            step();
        end
        wr_addr_inc = 1'b0;
        @(negedge clk);
        check_eq("b_addr500", {22'd0, addr}, 32'd500);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_write", {21'd0, busy, addr}, 32'd0);
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h13);
        @(negedge clk);
        check_eq("b_invalid_after_rst", {31'd0, busy}, 32'd0);

        // Silent write state.
        send_byte(8'h02);
`ifdef CMD_TIMEOUT_EN
        sb_q.push_back(EV_TIMEOUT);
        repeat (TMO - 1) step();
        @(negedge clk);
        check_eq("tmo_before", {31'd0, busy}, 32'd1);
        step();
        @(negedge clk);
        check_eq("tmo_fired", {21'd0, busy, addr}, 32'd0);
`else
        repeat (40) step();
        @(negedge clk);
        check_eq("no_tmo_busy", {31'd0, busy}, 32'd1);
        wr_job_ok = 1'b1;
        step();
        wr_job_ok = 1'b0;
`endif

        // Zero-length writes of both vectors, then reset during WAIT_OP.
        send_byte(8'h01);
        wr_job_ok = 1'b1; step(); wr_job_ok = 1'b0;
        send_byte(8'h02);
        wr_job_ok = 1'b1; step(); wr_job_ok = 1'b0;
        sb_q.push_back(EV_START | 8'h06);
        send_byte(8'h16);
        step();
        @(negedge clk);
        check_eq("wait6_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_op", {28'd0, busy, proc_op}, 32'd0);
        sb_q.push_back(EV_CMD_ERR);
        send_byte(8'h16);

        repeat (4) step();
        @(negedge clk);
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
